// File: rtl/neuron_layer_seq_if.sv
// rtl/neuron_layer_seq_if.sv - weight ROM, activation and result-stream bus of the layer controller
//
// Purpose: bundles the signals between the layer controller and its
// neighbours: the synchronous weight ROM, the combinational activation unit
// and the per-neuron result stream.
// Ports (signals):
//   w_addr    controller -> ROM   weight address (neuron*N_INPUTS + input)
//   w_rd      controller -> ROM   read enable
//   w_data    ROM -> controller   signed weight, valid the cycle after w_rd
//   act_sum   controller -> act   signed neuron sum
//   act_out   act -> controller   activation result, combinational from act_sum
//   out_valid controller -> sink  one-cycle pulse per neuron result
//   out_idx   controller -> sink  neuron index of the result
//   out_data  controller -> sink  activated result
// Modports: master = controller side, slave = environment side.
interface neuron_layer_seq_if #(
  parameter int N_NEURONS   = 8,
  parameter int N_INPUTS    = 4,
  parameter int WEIGHT_BITS = 3,
  parameter int SUM_BITS    = 6,
  parameter int OUTPUT_BITS = 3
);
  localparam int AW = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1;
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic [AW-1:0]          w_addr;
  logic                   w_rd;
  logic [WEIGHT_BITS-1:0] w_data;
  logic [SUM_BITS-1:0]    act_sum;
  logic [OUTPUT_BITS-1:0] act_out;
  logic                   out_valid;
  logic [NW-1:0]          out_idx;
  logic [OUTPUT_BITS-1:0] out_data;

  modport master (
    output w_addr, w_rd, act_sum, out_valid, out_idx, out_data,
    input  w_data, act_out
  );

  modport slave (
    input  w_addr, w_rd, act_sum, out_valid, out_idx, out_data,
    output w_data, act_out
  );
endinterface

// File: rtl/neuron_layer_seq.sv
// rtl/neuron_layer_seq.sv - time-multiplexed fully connected layer controller
//
// Purpose: evaluates N_NEURONS neurons one after another on a single signed
// multiply-accumulate path, presents each sum to an external activation unit,
// streams each activated result and keeps the whole layer output vector.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a layer run (sampled in IDLE only)
//   in_vec      layer inputs, input k at [k*INPUT_BITS +: INPUT_BITS]
//   bus         master side of neuron_layer_seq_if (ROM, activation, results)
//   out_vec     held layer result, neuron n at [n*OUTPUT_BITS +: OUTPUT_BITS]
//   busy        high from the cycle after start is accepted until done
//   done        one-cycle pulse at the end of a run
module neuron_layer_seq #(
  parameter int N_NEURONS   = 8,
  parameter int N_INPUTS    = 4,
  parameter int WEIGHT_BITS = 3,
  parameter int INPUT_BITS  = 1,
  parameter int SUM_BITS    = 6,
  parameter int OUTPUT_BITS = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [N_INPUTS*INPUT_BITS-1:0]   in_vec,
  neuron_layer_seq_if.master               bus,
  output logic [N_NEURONS*OUTPUT_BITS-1:0] out_vec,
  output logic                             busy,
  output logic                             done
);
  localparam int AW  = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1;
  localparam int NW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int KCW = $clog2(N_INPUTS + 1);

  typedef enum logic [1:0] {IDLE, ACC, ACT, FIN} state_t;

  state_t                       state_q;
  logic [INPUT_BITS-1:0]        in_q [N_INPUTS];
  logic [KCW-1:0]               k_q;
  logic [NW-1:0]                n_q;
  logic [AW-1:0]                w_addr_q;
  logic                         w_rd_q;
  logic signed [SUM_BITS-1:0]   acc_q;
  logic signed [SUM_BITS-1:0]   act_sum_q;
  logic [OUTPUT_BITS-1:0]       out_arr_q [N_NEURONS];
  logic                         out_valid_q;
  logic [NW-1:0]                out_idx_q;
  logic [OUTPUT_BITS-1:0]       out_data_q;
  logic                         busy_q;
  logic                         done_q;

  logic [INPUT_BITS-1:0]        x_raw;
  logic                         x_sign;
  logic signed [SUM_BITS-1:0]   w_ext;
  logic signed [SUM_BITS-1:0]   x_ext;
  logic signed [SUM_BITS-1:0]   prod;
  logic signed [SUM_BITS-1:0]   acc_d;

  // ACC cycle k consumes the weight fetched in cycle k-1, so it pairs with input k-1.
  always_comb begin
    x_raw = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (k_q == KCW'(i + 1)) x_raw = in_q[i];
    end
    x_sign = (INPUT_BITS > 1) ? x_raw[INPUT_BITS-1] : 1'b0;
    w_ext  = {{(SUM_BITS-WEIGHT_BITS){bus.w_data[WEIGHT_BITS-1]}}, bus.w_data};
    x_ext  = {{(SUM_BITS-INPUT_BITS){x_sign}}, x_raw};
    prod   = w_ext * x_ext;
    acc_d  = (k_q != '0) ? acc_q + prod : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      w_addr_q    <= '0;
      w_rd_q      <= 1'b0;
      acc_q       <= '0;
      act_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) in_q[i] <= '0;
      for (int i = 0; i < N_NEURONS; i++) out_arr_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      // Lags the state by one edge so busy rises the cycle after acceptance
      // and falls together with the done pulse.
      busy_q      <= (state_q == ACC) || (state_q == ACT);
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_INPUTS; i++) in_q[i] <= in_vec[i*INPUT_BITS +: INPUT_BITS];
            n_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            w_rd_q   <= 1'b1;
            w_addr_q <= '0;
            state_q  <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          if (k_q == KCW'(N_INPUTS)) begin
            act_sum_q <= acc_d;
            w_rd_q    <= 1'b0;
            state_q   <= ACT;
          end else begin
            k_q <= k_q + 1'b1;
            // The last fetch was issued at k = N_INPUTS-1; the final ACC cycle only accumulates.
            if (k_q == KCW'(N_INPUTS - 1)) begin
              w_rd_q <= 1'b0;
            end else begin
              w_rd_q   <= 1'b1;
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
        end
        ACT: begin
          out_valid_q    <= 1'b1;
          out_idx_q      <= n_q;
          out_data_q     <= bus.act_out;
          out_arr_q[n_q] <= bus.act_out;
          if (n_q == NW'(N_NEURONS - 1)) begin
            state_q <= FIN;
          end else begin
            // Addresses are contiguous across neurons, so the next one starts one past the last fetch.
            n_q      <= n_q + 1'b1;
            k_q      <= '0;
            acc_q    <= '0;
            w_rd_q   <= 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
            state_q  <= ACC;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.w_addr    = w_addr_q;
  assign bus.w_rd      = w_rd_q;
  assign bus.act_sum   = act_sum_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign done          = done_q;

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_out_vec
    assign out_vec[g*OUTPUT_BITS +: OUTPUT_BITS] = out_arr_q[g];
  end
endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb/tb_neuron_layer_seq.sv - self-checking bench for neuron_layer_seq
//
// Purpose: drives table vectors and hand-written corner sequences into a
// two-neuron, four-input instance with a behavioural weight ROM and SQNL
// activation unit; results are checked through an expected-result queue.
module tb_neuron_layer_seq;
  localparam int NN = 2;
  localparam int NI = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [NI-1:0] in_vec;
  logic [NN*3-1:0] out_vec;
  logic         busy;
  logic         done;

  neuron_layer_seq_if #(.N_NEURONS(NN), .N_INPUTS(NI), .WEIGHT_BITS(3),
                        .SUM_BITS(6), .OUTPUT_BITS(3)) bus ();

  neuron_layer_seq #(.N_NEURONS(NN), .N_INPUTS(NI), .WEIGHT_BITS(3), .INPUT_BITS(1),
                     .SUM_BITS(6), .OUTPUT_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
    .bus(bus), .out_vec(out_vec), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quantized SQNL: input scaled by 1/4, output scaled by 4 and clamped to 3 bits.
  function automatic logic [2:0] act_fn(int s);
    int y;
    if (s >= 8)       y = 3;
    else if (s <= -8) y = -4;
    else if (s >= 0)  y = s - (s * s) / 16;
    else              y = s + (s * s) / 16;
    if (y > 3)  y = 3;
    if (y < -4) y = -4;
    return y[2:0];
  endfunction

  logic [2:0] rom [NN*NI];
  logic [2:0] w_data_q = '0;
  always @(posedge clk) if (bus.w_rd) w_data_q <= rom[bus.w_addr];
  assign bus.w_data  = w_data_q;
  assign bus.act_out = act_fn(int'($signed(bus.act_sum)));

  typedef struct {
    logic [3:0] in;
    int         w [8];
    int         s0;
    int         s1;
  } vec_t;

  typedef struct {
    int         idx;
    int         sum;
    logic [2:0] data;
  } exp_t;

  vec_t tbl [6];
  exp_t sb [$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  task automatic chk(string nm, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra_valid", int'(bus.out_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_idx", int'(bus.out_idx), e.idx);
        chk("sb_sum", int'($signed(bus.act_sum)), e.sum);
        chk("sb_data", int'(bus.out_data), int'(e.data));
      end
    end
  end

  task automatic load_vec(int vi);
    for (int i = 0; i < NN*NI; i++) rom[i] = 3'(tbl[vi].w[i]);
    in_vec = tbl[vi].in;
  endtask

  task automatic push_exp(int vi);
    exp_t e;
    e.idx = 0; e.sum = tbl[vi].s0; e.data = act_fn(tbl[vi].s0); sb.push_back(e);
    e.idx = 1; e.sum = tbl[vi].s1; e.data = act_fn(tbl[vi].s1); sb.push_back(e);
  endtask

  // t counts samples taken 1 time unit after each edge, t=0 at the accepting edge.
  task automatic run_vec(int vi, int pulse_t, bit chg_in);
    int bad_busy, bad_valid, bad_done, bad_rd, bad_addr;
    logic [5:0] ev;
    bad_busy = 0; bad_valid = 0; bad_done = 0; bad_rd = 0; bad_addr = 0;
    load_vec(vi);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(vi);
    for (int t = 0; t <= 20; t++) begin
      bit e_rd;
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      e_rd = (t < 12) && ((t % 6) < 4);
      if (busy !== ((t >= 1) && (t <= 12))) bad_busy++;
      if (bus.out_valid !== ((t == 6) || (t == 12))) bad_valid++;
      if (done !== (t == 13)) bad_done++;
      if (bus.w_rd !== e_rd) bad_rd++;
      if (e_rd && (int'(bus.w_addr) != (t / 6) * 4 + (t % 6))) bad_addr++;
      if (chg_in && t == 1) in_vec = '0;
      if (t == pulse_t) start = 1'b1;
      if (t == pulse_t + 1) start = 1'b0;
    end
    chk($sformatf("busy_window_v%0d", vi), bad_busy, 0);
    chk($sformatf("valid_timing_v%0d", vi), bad_valid, 0);
    chk($sformatf("done_timing_v%0d", vi), bad_done, 0);
    chk($sformatf("w_rd_seq_v%0d", vi), bad_rd, 0);
    chk($sformatf("w_addr_seq_v%0d", vi), bad_addr, 0);
    ev = {act_fn(tbl[vi].s1), act_fn(tbl[vi].s0)};
    chk($sformatf("out_vec_v%0d", vi), int'(out_vec), int'(ev));
    chk($sformatf("sb_drained_v%0d", vi), sb.size(), 0);
  endtask

  initial begin
    tbl[0] = '{4'b1011, '{1, 2, -1, 3, -4, -4, -4, -4}, 6, -12};
    tbl[1] = '{4'b1111, '{-4, -4, -4, -4, -4, -4, -4, -4}, -16, -16};
    tbl[2] = '{4'b0000, '{1, 2, -1, 3, -4, -4, -4, -4}, 0, 0};
    tbl[3] = '{4'b0101, '{3, -2, 3, 1, -1, 2, -3, 0}, 6, -4};
    tbl[4] = '{4'b1111, '{3, 3, 3, 3, 3, 3, 3, 3}, 12, 12};
    tbl[5] = '{4'b0110, '{2, -3, 1, -4, 0, 1, -2, 3}, -2, -1};

    rst_n = 1'b0;
    start = 1'b0;
    in_vec = '0;
    for (int i = 0; i < NN*NI; i++) rom[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_w_rd", int'(bus.w_rd), 0);
    chk("rst_act_sum", int'(bus.act_sum), 0);
    chk("rst_out_vec", int'(out_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, -1, 1'b0);

    // start pulsed mid-run, then start pulsed during FIN: neither may restart
    run_vec(0, 2, 1'b0);
    run_vec(0, 12, 1'b0);

    // in_vec cleared right after acceptance, then a genuine all-zero run
    run_vec(0, -1, 1'b1);
    run_vec(2, -1, 1'b0);

    // asynchronous reset during neuron 1 accumulation
    run_vec(4, -1, 1'b0);
    load_vec(0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(0);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_w_rd", int'(bus.w_rd), 0);
    chk("midrst_w_addr", int'(bus.w_addr), 0);
    chk("midrst_act_sum", int'(bus.act_sum), 0);
    chk("midrst_out_vec", int'(out_vec), 0);
    chk("midrst_out_data", int'(bus.out_data), 0);
    chk("midrst_sb_left", sb.size(), 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0, -1, 1'b0);

    // extremes: every product -4, full-scale negative sum
    run_vec(1, -1, 1'b0);
    chk("extreme_act_sum", int'($signed(bus.act_sum)), -16);
    chk("extreme_out_data", int'(bus.out_data), 4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/neuron_layer_seq.md
Name: neuron_layer_seq

Overview:
- Time-multiplexed controller for one fully connected layer of the quantized decoder network.
- Shares a single signed multiply-accumulate path and one external combinational SQNL activation unit across N_NEURONS neurons.
- Fetches weights from a synchronous-read weight ROM, accumulates one product per cycle, and presents each neuron's sum to the activation unit.
- Captures each activated result and streams it out; also holds the full layer output vector until the next run.

Parameters:
- N_NEURONS, 8, neurons evaluated per run.
- N_INPUTS, 4, inputs per neuron.
- WEIGHT_BITS, 3, signed weight width.
- INPUT_BITS, 1, input width: unsigned when 1, signed two's complement when >1.
- SUM_BITS, 6, accumulator width; sized so a full neuron cannot overflow.
- OUTPUT_BITS, 3, activation output width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a layer run; sampled in IDLE only.
- in_vec  in  N_INPUTS*INPUT_BITS  layer inputs; input k at bits [k*INPUT_BITS +: INPUT_BITS].
- w_addr  out  clog2(N_NEURONS*N_INPUTS)  weight ROM address = neuron*N_INPUTS + input.
- w_rd  out  1  ROM read enable.
- w_data  in  WEIGHT_BITS  signed ROM data, valid the cycle after w_rd.
- act_sum  out  SUM_BITS  signed sum driven to the activation unit.
- act_out  in  OUTPUT_BITS  activation result, combinational from act_sum.
- out_valid  out  1  one-cycle pulse per neuron result.
- out_idx  out  clog2(N_NEURONS)  index of the neuron being reported.
- out_data  out  OUTPUT_BITS  activated result.
- out_vec  out  N_NEURONS*OUTPUT_BITS  held layer result.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst_n low): state IDLE; clear every output, the accumulator, both counters and out_vec to 0. Reset mid-run aborts immediately; no partial results are kept.
- States: IDLE, ACC, ACT, FIN.
- IDLE:
  - start=1: latch in_vec into an internal register, set neuron counter n=0 and input counter k=0, go to ACC.
  - start=0: stay in IDLE.
- ACC lasts N_INPUTS+1 cycles per neuron.
  - Cycle c (0..N_INPUTS-1): w_rd=1, w_addr=n*N_INPUTS+c.
  - Cycle c (1..N_INPUTS): acc += sext(w_data) * input[c-1], with the product sign-extended to SUM_BITS.
  - acc is cleared on entry to ACC.
  - Wrap-around arithmetic, no saturation.
  - w_rd=0 on the final ACC cycle.
- ACT (1 cycle):
  - act_sum=acc; out_data<=act_out; out_idx<=n; out_valid=1 on the following cycle edge.
  - out_vec slice n is updated.
  - If n==N_NEURONS-1, go to FIN; else n++ and go to ACC.
- FIN (1 cycle): done=1, busy falls to 0, return to IDLE.
- act_sum holds its last value outside ACT; out_vec holds until the next accepted start.
- Latency: start accepted at edge E → first out_valid at E+N_INPUTS+2 → done at E+N_NEURONS*(N_INPUTS+2)+1.
- start is ignored while busy; no queuing.
- start asserted in the FIN cycle is also ignored; the new run is accepted in IDLE only.
- in_vec changes after acceptance have no effect on the current run.

Test Plan:
- Basic run:
  - Setup: N_NEURONS=2, N_INPUTS=4, in_vec=4'b1011, weights n0={1,2,-1,3}, n1={-4,-4,-4,-4}.
  - Required: sums 6 and -12 presented on act_sum, in that order.
  - Required: out_valid pulses at E+6 (idx0) and E+12 (idx1); done at E+13; busy high E+1..E+12.
- Address sequence: w_addr runs 0,1,2,3 then 4,5,6,7; w_rd is low on every ACT/FIN cycle and on the last ACC cycle of each neuron.
- Busy protection: pulse start during neuron 0 → no restart; results identical to the basic run; exactly one done pulse.
- Mid-run reset: assert rst_n=0 during neuron 1 ACC → all outputs 0 asynchronously. After release, a fresh start produces correct results.
- Input latch: change in_vec to 0 one cycle after start → sums unchanged (6, -12). A second run then gives sums 0 and 0, and out_vec updates accordingly.
- Extremes:
  - Setup: all weights -4, in_vec all ones, N_INPUTS=4.
  - Required: act_sum = -16 exactly, no wrap.
  - Required: out_data equals the activation unit's negative-saturated code (100b for OUTPUT_BITS=3).
